ham_15_11_decoder: RTL

//  Downstream stage of the (15,11) Hamming encoder: accepts 15-bit codewords, computes the 4-bit

---
 rtl/ham_pkg.sv | 21 ++
 rtl/ham_15_11_decoder_if.sv | 20 ++
 rtl/ham_15_11_syndrome.sv | 9 +
 rtl/ham_15_11_decoder.sv | 61 ++++++
 4 files changed

// File: rtl/ham_pkg.sv
// ham_pkg: shared (15,11) Hamming bit map, widths and syndrome/extract helpers
package ham_pkg;
  localparam int CODE_W = 15;
  localparam int DATA_W = 11;
  localparam int SYN_W = 4;
  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int P4_IDX = 3;
  localparam int P8_IDX = 7;
  function automatic logic [SYN_W-1:0] ham_syndrome(input logic [CODE_W-1:0] c);
    logic [SYN_W-1:0] s;
    s = '0;
    for (int i = 0; i < CODE_W; i++)
      for (int k = 0; k < SYN_W; k++)
        if (((i + 1) & (1 << k)) != 0) s[k] = s[k] ^ c[i];
    return s;
  endfunction
  function automatic logic [DATA_W-1:0] ham_extract(input logic [CODE_W-1:0] c);
    return {c[14:8], c[6:4], c[2]};
  endfunction
endpackage

// File: rtl/ham_15_11_decoder_if.sv
// ham_15_11_decoder_if: codeword-in / data-out valid-ready streams of the decoder
interface ham_15_11_decoder_if;
  import ham_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [CODE_W-1:0] c_in;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] d_out;
  logic err_corrected;
  logic [SYN_W-1:0] err_pos;
  modport master (
    output in_valid, c_in, out_ready,
    input in_ready, out_valid, d_out, err_corrected, err_pos
  );
  modport slave (
    input in_valid, c_in, out_ready,
    output in_ready, out_valid, d_out, err_corrected, err_pos
  );
endinterface

// File: rtl/ham_15_11_syndrome.sv
// ham_15_11_syndrome: combinational codeword -> 4-bit syndrome
module ham_15_11_syndrome
  import ham_pkg::*;
(
  input logic [CODE_W-1:0] c,
  output logic [SYN_W-1:0] s
);
  assign s = ham_syndrome(c);
endmodule

// File: rtl/ham_15_11_decoder.sv
// ham_15_11_decoder: 2-stage SEC decoder with valid/ready backpressure.
// Define HAM_DEC_STATS_EN to build the saturating corrected-word counter.
module ham_15_11_decoder
  import ham_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  ham_15_11_decoder_if.slave bus,
  input logic clr_cnt,
  output logic [CNT_W-1:0] corr_cnt
);
  logic s1_valid, s2_valid, s2_load;
  logic [CODE_W-1:0] s1_c, fixed;
  logic [SYN_W-1:0] s1_s, syn;
  ham_15_11_syndrome u_syn (.c(bus.c_in), .s(syn));
  always_comb begin
    s2_load = s1_valid && (!s2_valid || bus.out_ready);
    bus.in_ready = !s1_valid || s2_load;
    fixed = (s1_s != '0) ? s1_c ^ (CODE_W'(1) << (s1_s - SYN_W'(1))) : s1_c;
  end
  assign bus.out_valid = s2_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_c <= '0;
      s1_s <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_c <= bus.c_in;
        s1_s <= syn;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s2_valid <= 1'b0;
      bus.d_out <= '0;
      bus.err_corrected <= 1'b0;
      bus.err_pos <= '0;
    end else begin
      s2_valid <= s2_load || (s2_valid && !bus.out_ready);
      if (s2_load) begin
        bus.d_out <= ham_extract(fixed);
        bus.err_corrected <= s1_s != '0;
        bus.err_pos <= s1_s;
      end
    end
`ifdef HAM_DEC_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) corr_cnt <= '0;
    else if (clr_cnt) corr_cnt <= '0;
    else if (bus.out_valid && bus.out_ready && bus.err_corrected && !(&corr_cnt))
      corr_cnt <= corr_cnt + CNT_W'(1);
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign corr_cnt = '0;
`endif
endmodule
